// File: rtl/pq_pkg.sv
// Shared types for the heap priority-queue command front-end.
// The count-width helper is shared with the queue so both size occupancy the same way.
package pq_pkg;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } sched_state_t;

    function automatic int count_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/pq_cmd_fifo.sv
// Request buffer for the scheduler: a synchronous FIFO whose head is visible combinationally.
// A full FIFO refuses writes even when the head leaves in the same cycle.
module pq_cmd_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pq_cmd_sched.sv
// Command front-end for the BRAM heap priority queue: buffers push/pop/replace requests,
// issues them as spaced i_wrt/i_read pulses and returns the pre-removal top as a result stream.
//
//   state | meaning
//   IDLE  | waiting for a request at the FIFO head
//   ISSUE | command pulse on q_wrt/q_read, result and occupancy captured
//   GAP   | heap settling; last GAP cycle may already decide the next head
module pq_cmd_sched
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int QUEUE_SIZE = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_GAP    = 8
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [1:0]                            s_op,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    output logic                                  q_wrt,
    output logic                                  q_read,
    output logic [DATA_WIDTH-1:0]                 q_data,
    input  logic [DATA_WIDTH-1:0]                 q_top,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic [count_width(QUEUE_SIZE)-1:0]    o_count,
    output logic                                  o_err
);

    localparam int              CW        = count_width(QUEUE_SIZE);
    localparam logic [CW-1:0]   COUNT_MAX = CW'(QUEUE_SIZE);
    localparam int              GW        = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam logic [GW-1:0]   GAP_LOAD  = GW'(CMD_GAP - 1);

    sched_state_t          state;
    logic [GW-1:0]         gap_cnt;
    op_t                   cur_op;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [DATA_WIDTH+1:0] head;
    op_t                   head_op;
    logic [DATA_WIDTH-1:0] head_key;
    logic                  decide;
    logic                  drop;
    logic                  stall;
    logic                  take;
    logic                  issue;

    assign s_ready = !RST && !fifo_full;
    assign fifo_wr = s_valid && s_ready;

    pq_cmd_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (fifo_wr),
        .wr_data ({s_op, s_data}),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Deciding in the terminal GAP cycle keeps pulse spacing at CMD_GAP+1.
    always_comb begin
        head_op  = op_t'(head[DATA_WIDTH+1:DATA_WIDTH]);
        head_key = head[DATA_WIDTH-1:0];
        decide   = (state == IDLE) || ((state == GAP) && (gap_cnt == '0));
        drop     = (head_op == OP_ILLEGAL)
                || ((head_op == OP_POP)  && (o_count == '0))
                || ((head_op == OP_PUSH) && (o_count == COUNT_MAX));
        stall    = !drop && ((head_op == OP_POP) || (head_op == OP_REPLACE))
                && m_valid && !m_ready;
        take     = decide && !fifo_empty && !stall;
        issue    = take && !drop;
        fifo_rd  = take;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            gap_cnt <= '0;
            cur_op  <= OP_PUSH;
            q_wrt   <= 1'b0;
            q_read  <= 1'b0;
            q_data  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            o_count <= '0;
            o_err   <= 1'b0;
        end else begin
            q_wrt  <= 1'b0;
            q_read <= 1'b0;
            o_err  <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: ;
                ISSUE: begin
                    case (cur_op)
                        OP_PUSH: o_count <= o_count + 1'b1;
                        OP_POP: begin
                            o_count <= o_count - 1'b1;
                            m_data  <= q_top;
                            m_valid <= 1'b1;
                        end
                        OP_REPLACE: begin
                            m_data  <= q_top;
                            m_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                    gap_cnt <= GAP_LOAD;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (decide) begin
                state <= IDLE;
                if (take && drop) begin
                    o_err <= 1'b1;
                end
                if (issue) begin
                    state  <= ISSUE;
                    q_data <= head_key;
                    if ((head_op == OP_REPLACE) && (o_count == '0)) begin
                        cur_op <= OP_PUSH;
                        q_wrt  <= 1'b1;
                    end else begin
                        cur_op <= head_op;
                        q_wrt  <= (head_op != OP_POP);
                        q_read <= (head_op != OP_PUSH);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pq_cmd_sched.sv
// Directed bench for pq_cmd_sched: a vector table of single commands plus hand-built
// sequences for spacing, FIFO back-pressure, result stalls and mid-operation reset.
module tb_pq_cmd_sched;
    import pq_pkg::*;

    localparam int DW = 16;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    s_op = 2'b00;
    logic [DW-1:0] s_data = '0;
    logic          q_wrt;
    logic          q_read;
    logic [DW-1:0] q_data;
    logic [DW-1:0] q_top = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic [CW-1:0] o_count;
    logic          o_err;

    always #5 CLK = ~CLK;

    pq_cmd_sched #(
        .DATA_WIDTH (DW),
        .QUEUE_SIZE (7),
        .FIFO_DEPTH (4),
        .CMD_GAP    (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_op    (s_op),
        .s_data  (s_data),
        .q_wrt   (q_wrt),
        .q_read  (q_read),
        .q_data  (q_data),
        .q_top   (q_top),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .o_count (o_count),
        .o_err   (o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Negedge monitor: running totals only, tests work on deltas.
    int            cyc = 0;
    int            n_wrt = 0, n_rd = 0, n_err = 0, n_mhs = 0, n_srlow = 0;
    logic [DW-1:0] last_qdata = '0;
    logic [DW-1:0] last_mdata = '0;
    int            wrt_cyc[$];
    logic [DW-1:0] wrt_data[$];

    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (q_wrt) begin
                n_wrt++;
                wrt_cyc.push_back(cyc);
                wrt_data.push_back(q_data);
            end
            if (q_read) n_rd++;
            if (q_wrt || q_read) last_qdata = q_data;
            if (o_err) n_err++;
            if (m_valid && m_ready) begin
                n_mhs++;
                last_mdata = m_data;
            end
            if (!s_ready) n_srlow++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [DW-1:0] data);
        int k;
        s_valid = 1'b1;
        s_op    = op;
        s_data  = data;
        k = 0;
        while (!s_ready && k < 50) begin
            tick();
            k++;
        end
        check("send_ready_timeout", (k < 50), 1);
        tick();
        s_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        logic [DW-1:0] top;
        int            wrt;
        int            rd;
        int            err;
        logic [DW-1:0] qdata;
        int            count;
        int            mhs;
        logic [DW-1:0] mdata;
    } vec_t;

    vec_t vt[8];

    initial begin
        int b_wrt, b_rd, b_err, b_mhs, b_sr, b_q;

        vt[0] = '{2'b10, 16'd0,  16'd0,  0, 0, 1, 16'd0,  0, 0, 16'd0};
        vt[1] = '{2'b11, 16'd17, 16'd0,  1, 0, 0, 16'd17, 1, 0, 16'd0};
        vt[2] = '{2'b11, 16'd20, 16'd17, 1, 1, 0, 16'd20, 1, 1, 16'd17};
        vt[3] = '{2'b01, 16'd30, 16'd17, 1, 0, 0, 16'd30, 2, 0, 16'd0};
        vt[4] = '{2'b00, 16'd99, 16'd17, 0, 0, 1, 16'd0,  2, 0, 16'd0};
        vt[5] = '{2'b10, 16'd0,  16'd30, 0, 1, 0, 16'd0,  1, 1, 16'd30};
        vt[6] = '{2'b10, 16'd0,  16'd20, 0, 1, 0, 16'd0,  0, 1, 16'd20};
        vt[7] = '{2'b10, 16'd0,  16'd20, 0, 0, 1, 16'd0,  0, 0, 16'd0};

        // Reset state
        RST = 1'b1;
        repeat (3) tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_q_wrt",   q_wrt,   0);
        check("rst_m_valid", m_valid, 0);
        check("rst_o_count", o_count, 0);
        RST = 1'b0;
        tick();
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_o_err",   o_err,   0);

        // Single-command vector table
        for (int i = 0; i < 8; i++) begin
            q_top   = vt[i].top;
            m_ready = 1'b1;
            b_wrt = n_wrt; b_rd = n_rd; b_err = n_err; b_mhs = n_mhs;
            send(vt[i].op, vt[i].data);
            repeat (12) tick();
            check($sformatf("v%0d_wrt", i),   n_wrt - b_wrt, vt[i].wrt);
            check($sformatf("v%0d_rd", i),    n_rd - b_rd,   vt[i].rd);
            check($sformatf("v%0d_err", i),   n_err - b_err, vt[i].err);
            check($sformatf("v%0d_count", i), o_count,       vt[i].count);
            check($sformatf("v%0d_mhs", i),   n_mhs - b_mhs, vt[i].mhs);
            if (vt[i].wrt + vt[i].rd > 0)
                check($sformatf("v%0d_qdata", i), last_qdata, vt[i].qdata);
            if (vt[i].mhs > 0)
                check($sformatf("v%0d_mdata", i), last_mdata, vt[i].mdata);
        end

        // Back-to-back pushes: spacing and order
        b_wrt = n_wrt; b_sr = n_srlow; b_q = wrt_cyc.size();
        send(2'b01, 16'd5);
        send(2'b01, 16'd3);
        send(2'b01, 16'd9);
        repeat (35) tick();
        check("seqA_wrt_pulses", n_wrt - b_wrt, 3);
        if (wrt_cyc.size() >= b_q + 3) begin
            check("seqA_gap1",  wrt_cyc[b_q+1] - wrt_cyc[b_q],   9);
            check("seqA_gap2",  wrt_cyc[b_q+2] - wrt_cyc[b_q+1], 9);
            check("seqA_data0", wrt_data[b_q],   5);
            check("seqA_data1", wrt_data[b_q+1], 3);
            check("seqA_data2", wrt_data[b_q+2], 9);
        end
        check("seqA_count",   o_count,         3);
        check("seqA_sr_low",  n_srlow - b_sr,  0);

        // Five pushes: FIFO fills for 6 cycles, queue fills to 7, last push dropped
        b_wrt = n_wrt; b_err = n_err; b_sr = n_srlow;
        send(2'b01, 16'd11);
        send(2'b01, 16'd12);
        send(2'b01, 16'd13);
        send(2'b01, 16'd14);
        send(2'b01, 16'd15);
        repeat (60) tick();
        check("seqB_sr_low",   n_srlow - b_sr, 6);
        check("seqB_wrt",      n_wrt - b_wrt,  4);
        check("seqB_err",      n_err - b_err,  1);
        check("seqB_count",    o_count,        7);
        check("seqB_last_wrt", wrt_data[wrt_cyc.size()-1], 14);

        // Result stall: second pop withheld until m_ready
        m_ready = 1'b0;
        q_top   = 16'd42;
        b_rd = n_rd; b_mhs = n_mhs;
        send(2'b10, 16'd0);
        send(2'b10, 16'd0);
        repeat (25) tick();
        check("seqC_rd_stalled", n_rd - b_rd, 1);
        check("seqC_m_valid",    m_valid,     1);
        check("seqC_m_data",     m_data,      42);
        check("seqC_count1",     o_count,     6);
        check("seqC_no_hs",      n_mhs - b_mhs, 0);
        q_top   = 16'd41;
        m_ready = 1'b1;
        repeat (15) tick();
        check("seqC_rd_after",   n_rd - b_rd,   2);
        check("seqC_count2",     o_count,       5);
        check("seqC_hs",         n_mhs - b_mhs, 2);
        check("seqC_mdata2",     last_mdata,    41);
        check("seqC_m_valid_clr", m_valid,      0);

        // Reset during GAP with three requests buffered
        send(2'b01, 16'd21);
        send(2'b01, 16'd22);
        send(2'b01, 16'd23);
        send(2'b01, 16'd24);
        RST = 1'b1;
        tick();
        check("seqD_rst_s_ready", s_ready, 0);
        check("seqD_rst_q_wrt",   q_wrt,   0);
        check("seqD_rst_q_read",  q_read,  0);
        check("seqD_rst_q_data",  q_data,  0);
        check("seqD_rst_m_valid", m_valid, 0);
        check("seqD_rst_m_data",  m_data,  0);
        check("seqD_rst_count",   o_count, 0);
        check("seqD_rst_err",     o_err,   0);
        RST = 1'b0;
        b_wrt = n_wrt; b_rd = n_rd;
        repeat (20) tick();
        check("seqD_quiet_wrt",  n_wrt - b_wrt, 0);
        check("seqD_quiet_rd",   n_rd - b_rd,   0);
        check("seqD_quiet_cnt",  o_count,       0);
        send(2'b01, 16'd50);
        repeat (12) tick();
        check("seqD_new_wrt",   n_wrt - b_wrt, 1);
        check("seqD_new_data",  last_qdata,    50);
        check("seqD_new_count", o_count,       1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
